periph_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the SoC's single peripheral register port (GPIO in/out registers, PWM configuration registers) among up to NUM_REQ bus masters (CPU core, DMA, debug).
- One transaction at a time: grant, drive the shared bus, wait for the slave ready, return read data and a completion pulse.
- Sits between the masters and the peripheral address decoder inside SOC.

---
 rtl/soc_bus_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/periph_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding, default widths
// and the all-ones read data returned when an aborted transfer completes.
package soc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } arbState_t;

   localparam int DEFAULT_ADDR_W = 8;
   localparam int DEFAULT_DATA_W = 16;

   // Wide enough for any DATA_W in use; slice to the bus width at the use site.
   localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo NUM_REQ, as both a one-hot vector and an index.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winnerOneHot,
   output logic [IDX_W-1:0]   winnerIdx,
   output logic               anyReq
);

   logic [IDX_W-1:0] candIdx;

   always_comb begin
      winnerOneHot = '0;
      winnerIdx    = '0;
      anyReq       = 1'b0;
      candIdx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         candIdx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!anyReq && req[candIdx]) begin
            anyReq                = 1'b1;
            winnerIdx             = candIdx;
            winnerOneHot[candIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin sequencer sharing one peripheral register port among NUM_REQ masters.
// Define PERIPH_ARB_TIMEOUT_EN to abort transfers that wait TIMEOUT cycles for bus_ready.
module periph_bus_arbiter
   import soc_bus_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      timeout_err,
   output logic                      bus_valid,
   output logic                      bus_we,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [DATA_W-1:0]         bus_wdata,
   input  logic                      bus_ready,
   input  logic [DATA_W-1:0]         bus_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : gBadParams
      $error("periph_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
   end

   arbState_t            stateReg;
   logic [IDX_W-1:0]     ptrReg;
   logic [IDX_W-1:0]     winnerReg;
   logic [NUM_REQ-1:0]   gntReg;
   logic [NUM_REQ-1:0]   doneReg;
   logic [DATA_W-1:0]    rdataReg;
   logic                 busValidReg;
   logic                 busWeReg;
   logic [ADDR_W-1:0]    busAddrReg;
   logic [DATA_W-1:0]    busWdataReg;

   logic [NUM_REQ-1:0]   pickOneHot;
   logic [IDX_W-1:0]     pickIdx;
   logic                 pickAny;
   logic                 timeoutHit;
   logic [IDX_W-1:0]     ptrNext;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uPicker (
      .req          (req),
      .ptr          (ptrReg),
      .winnerOneHot (pickOneHot),
      .winnerIdx    (pickIdx),
      .anyReq       (pickAny)
   );

   // The master just served drops to lowest priority.
   assign ptrNext = (winnerReg == IDX_W'(NUM_REQ - 1)) ? '0 : winnerReg + 1'b1;

`ifdef PERIPH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] waitCntReg;
   logic             timeoutErrReg;

   // Fires on the TIMEOUT-th XFER cycle that has seen no bus_ready.
   assign timeoutHit  = (stateReg == XFER) && !bus_ready && (waitCntReg == CNT_LAST);
   assign timeout_err = timeoutErrReg;
`else
   assign timeoutHit  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg      <= IDLE;
         ptrReg        <= '0;
         winnerReg     <= '0;
         gntReg        <= '0;
         doneReg       <= '0;
         rdataReg      <= '0;
         busValidReg   <= 1'b0;
         busWeReg      <= 1'b0;
         busAddrReg    <= '0;
         busWdataReg   <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
         waitCntReg    <= '0;
         timeoutErrReg <= 1'b0;
`endif
      end else begin
         doneReg <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
         timeoutErrReg <= 1'b0;
`endif
         case (stateReg)
            IDLE: begin
               if (pickAny) begin
                  winnerReg   <= pickIdx;
                  gntReg      <= pickOneHot;
                  busValidReg <= 1'b1;
                  busWeReg    <= req_we[pickIdx];
                  busAddrReg  <= req_addr[pickIdx*ADDR_W +: ADDR_W];
                  busWdataReg <= req_wdata[pickIdx*DATA_W +: DATA_W];
                  stateReg    <= XFER;
`ifdef PERIPH_ARB_TIMEOUT_EN
                  waitCntReg  <= '0;
`endif
               end
            end

            XFER: begin
               if (bus_ready || timeoutHit) begin
                  busValidReg <= 1'b0;
                  busWeReg    <= 1'b0;
                  busAddrReg  <= '0;
                  busWdataReg <= '0;
                  gntReg      <= '0;
                  doneReg     <= gntReg;
                  ptrReg      <= ptrNext;
                  stateReg    <= DONE;
                  if (bus_ready) begin
                     if (!busWeReg) begin
                        rdataReg <= bus_rdata;
                     end
                  end else begin
                     rdataReg <= TIMEOUT_RDATA[DATA_W-1:0];
`ifdef PERIPH_ARB_TIMEOUT_EN
                     timeoutErrReg <= 1'b1;
`endif
                  end
               end
`ifdef PERIPH_ARB_TIMEOUT_EN
               else begin
                  waitCntReg <= waitCntReg + 1'b1;
               end
`endif
            end

            DONE: begin
               stateReg <= IDLE;
            end

            default: begin
               stateReg <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gntReg;
   assign done      = doneReg;
   assign rdata     = rdataReg;
   assign bus_valid = busValidReg;
   assign bus_we    = busWeReg;
   assign bus_addr  = busAddrReg;
   assign bus_wdata = busWdataReg;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter; honours PERIPH_ARB_TIMEOUT_EN when defined.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [N-1:0]     req = '0;
   logic [N-1:0]     req_we = '0;
   logic [N*AW-1:0]  req_addr = '0;
   logic [N*DW-1:0]  req_wdata = '0;
   logic [N-1:0]     gnt;
   logic [N-1:0]     done;
   logic [DW-1:0]    rdata;
   logic             timeout_err;
   logic             bus_valid;
   logic             bus_we;
   logic [AW-1:0]    bus_addr;
   logic [DW-1:0]    bus_wdata;
   logic             bus_ready = 1'b0;
   logic [DW-1:0]    bus_rdata = '0;

   int nCompared = 0;
   int nMismatched = 0;

   periph_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .done        (done),
      .rdata       (rdata),
      .timeout_err (timeout_err),
      .bus_valid   (bus_valid),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_ready   (bus_ready),
      .bus_rdata   (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      req = '0; bus_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [63:0] allOut;
      #1 rst_n = 1'b0;
      #2;
      allOut = {gnt, done, rdata, timeout_err, bus_valid, bus_we, bus_addr, bus_wdata};
      nCompared++;
      if (allOut !== 64'(0)) begin
         nMismatched++;
         $display("FAIL reset_async outputs got %h want 0", allOut);
      end
      @(negedge clk);
      @(negedge clk);
      allOut = {gnt, done, rdata, timeout_err, bus_valid, bus_we, bus_addr, bus_wdata};
      nCompared++;
      if (allOut !== 64'(0)) begin
         nMismatched++;
         $display("FAIL reset_held outputs got %h want 0", allOut);
      end
      rst_n = 1'b1;
      $display("reset: outputs checked");
   endtask

   task automatic test_single_write();
      int validCycles = 0;
      req_we[0] = 1'b1; req_addr[0*AW +: AW] = 8'h10; req_wdata[0*DW +: DW] = 16'hAAAA;
      bus_ready = 1'b1; req[0] = 1'b1;
      @(negedge clk);
      if (bus_valid === 1'b1) validCycles++;
      nCompared++;
      if ({gnt, bus_valid, bus_we, bus_addr, bus_wdata} !== {4'b0001, 1'b1, 1'b1, 8'h10, 16'hAAAA}) begin
         nMismatched++;
         $display("FAIL write_bus gnt=%b valid=%b we=%b addr=%h data=%h want 0001/1/1/10/aaaa",
                  gnt, bus_valid, bus_we, bus_addr, bus_wdata);
      end
      @(negedge clk);
      if (bus_valid === 1'b1) validCycles++;
      nCompared++;
      if ({done, gnt} !== {4'b0001, 4'b0000}) begin
         nMismatched++;
         $display("FAIL write_done done=%b gnt=%b want 0001/0000", done, gnt);
      end
      req[0] = 1'b0;
      @(negedge clk);
      if (bus_valid === 1'b1) validCycles++;
      nCompared++;
      if (validCycles != 1 || done !== 4'b0000) begin
         nMismatched++;
         $display("FAIL write_valid_len valid cycles=%0d done=%b want 1/0000", validCycles, done);
      end
      bus_ready = 1'b0;
      $display("single_write: addr 10 data aaaa, valid cycles %0d", validCycles);
   endtask

   task automatic test_wait_read();
      req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'h20; bus_ready = 1'b0; req[2] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         nCompared++;
         if ({bus_valid, bus_we, bus_addr, gnt} !== {1'b1, 1'b0, 8'h20, 4'b0100}) begin
            nMismatched++;
            $display("FAIL read_wait_c%0d valid=%b we=%b addr=%h gnt=%b want 1/0/20/0100",
                     c, bus_valid, bus_we, bus_addr, gnt);
         end
         if (c == 5) begin
            bus_ready = 1'b1; bus_rdata = 16'h5555;
         end
      end
      @(negedge clk);
      nCompared++;
      if ({done, rdata, bus_valid} !== {4'b0100, 16'h5555, 1'b0}) begin
         nMismatched++;
         $display("FAIL read_done done=%b rdata=%h valid=%b want 0100/5555/0", done, rdata, bus_valid);
      end
      req[2] = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
      @(negedge clk);
      $display("wait_read: addr 20 rdata %h", rdata);
   endtask

   task automatic test_fairness();
      logic [N-1:0] expGnt, expDone;
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_we[i] = 1'b0; req_addr[i*AW +: AW] = AW'(8'h40 + i);
      end
      bus_ready = 1'b1; bus_rdata = 16'h0F0F; req = 4'b1111;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         expGnt  = (c % 3 == 1) ? 4'(1 << (((c - 1) / 3) % N)) : 4'b0000;
         expDone = (c % 3 == 2) ? 4'(1 << (((c - 2) / 3) % N)) : 4'b0000;
         nCompared++;
         if ({gnt, done} !== {expGnt, expDone}) begin
            nMismatched++;
            $display("FAIL fair_c%0d gnt=%b done=%b want %b/%b", c, gnt, done, expGnt, expDone);
         end
      end
      req = '0; bus_ready = 1'b0;
      $display("fairness: 5 grants checked over 15 cycles");
   endtask

   task automatic test_abandon();
      req_we[3] = 1'b1; req_addr[3*AW +: AW] = 8'h33; req_wdata[3*DW +: DW] = 16'h1234;
      bus_ready = 1'b0; req[3] = 1'b1;
      @(negedge clk);
      nCompared++;
      if ({gnt, bus_valid} !== {4'b1000, 1'b1}) begin
         nMismatched++;
         $display("FAIL abandon_gnt gnt=%b valid=%b want 1000/1", gnt, bus_valid);
      end
      req[3] = 1'b0;
      @(negedge clk);
      nCompared++;
      if ({gnt, bus_valid, bus_wdata} !== {4'b1000, 1'b1, 16'h1234}) begin
         nMismatched++;
         $display("FAIL abandon_hold gnt=%b valid=%b data=%h want 1000/1/1234", gnt, bus_valid, bus_wdata);
      end
      bus_ready = 1'b1;
      @(negedge clk);
      nCompared++;
      if ({done, rdata} !== {4'b1000, 16'h0F0F}) begin
         nMismatched++;
         $display("FAIL abandon_done done=%b rdata=%h want 1000/0f0f", done, rdata);
      end
      bus_ready = 1'b0;
      @(negedge clk);
      $display("abandon: done[3] seen, rdata %h", rdata);
   endtask

   task automatic test_timeout();
`ifdef PERIPH_ARB_TIMEOUT_EN
      localparam int WAITC = 15;
      localparam logic [DW-1:0] EXP_RD = 16'hFFFF;
      localparam logic EXP_TE = 1'b1;
`else
      localparam int WAITC = 20;
      localparam logic [DW-1:0] EXP_RD = 16'h0BEE;
      localparam logic EXP_TE = 1'b0;
`endif
      req_we[1] = 1'b0; req_addr[1*AW +: AW] = 8'h51; bus_ready = 1'b0; req[1] = 1'b1;
      for (int c = 1; c <= WAITC; c++) begin
         @(negedge clk);
         nCompared++;
         if ({bus_valid, timeout_err, done} !== {1'b1, 1'b0, 4'b0000}) begin
            nMismatched++;
            $display("FAIL timeout_wait_c%0d valid=%b terr=%b done=%b want 1/0/0000",
                     c, bus_valid, timeout_err, done);
         end
`ifndef PERIPH_ARB_TIMEOUT_EN
         if (c == WAITC) begin
            bus_ready = 1'b1; bus_rdata = 16'h0BEE;
         end
`endif
      end
      @(negedge clk);
      nCompared++;
      if ({bus_valid, done, timeout_err, rdata} !== {1'b0, 4'b0010, EXP_TE, EXP_RD}) begin
         nMismatched++;
         $display("FAIL timeout_end valid=%b done=%b terr=%b rdata=%h want 0/0010/%b/%h",
                  bus_valid, done, timeout_err, rdata, EXP_TE, EXP_RD);
      end
      req[1] = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
      @(negedge clk);
      nCompared++;
      if (timeout_err !== 1'b0) begin
         nMismatched++;
         $display("FAIL timeout_pulse terr=%b want 0", timeout_err);
      end
      $display("timeout: %0d wait cycles, rdata %h", WAITC, rdata);
   endtask

   task automatic test_async_reset();
      logic [63:0] allOut;
      req_we[0] = 1'b0; req_addr[0*AW +: AW] = 8'h07; bus_ready = 1'b0; req = 4'b0001;
      @(negedge clk);
      nCompared++;
      if ({gnt, bus_valid} !== {4'b0001, 1'b1}) begin
         nMismatched++;
         $display("FAIL areset_pre gnt=%b valid=%b want 0001/1", gnt, bus_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      allOut = {gnt, done, rdata, timeout_err, bus_valid, bus_we, bus_addr, bus_wdata};
      nCompared++;
      if (allOut !== 64'(0)) begin
         nMismatched++;
         $display("FAIL areset_mid outputs got %h want 0", allOut);
      end
      req = '0;
      @(negedge clk);
      nCompared++;
      if (done !== 4'b0000) begin
         nMismatched++;
         $display("FAIL areset_nodone done=%b want 0000", done);
      end
      rst_n = 1'b1;
      req_we[1] = 1'b0; req_we[3] = 1'b0; bus_ready = 1'b1; bus_rdata = 16'h7E57; req = 4'b1010;
      @(negedge clk);
      nCompared++;
      if (gnt !== 4'b0010) begin
         nMismatched++;
         $display("FAIL areset_first gnt=%b want 0010", gnt);
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      nCompared++;
      if (gnt !== 4'b1000) begin
         nMismatched++;
         $display("FAIL areset_second gnt=%b want 1000", gnt);
      end
      req = '0;
      @(negedge clk);
      nCompared++;
      if ({done, rdata} !== {4'b1000, 16'h7E57}) begin
         nMismatched++;
         $display("FAIL areset_done done=%b rdata=%h want 1000/7e57", done, rdata);
      end
      bus_ready = 1'b0;
      @(negedge clk);
      $display("async_reset: regrant order 1 then 3");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_wait_read();
      test_fairness();
      test_abandon();
      test_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
